// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU operation codes
// and the packed control bundle carried into the ID/EX register.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    ALUOP_ADD    = 4'd0,
    ALUOP_BRANCH = 4'd1,
    ALUOP_RTYPE  = 4'd2,
    ALUOP_AND    = 4'd3,
    ALUOP_OR     = 4'd4,
    ALUOP_SLT    = 4'd5,
    ALUOP_LUI    = 4'd6
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_dst;
    logic    mem_write;
    logic    mem_read;
    logic    branch;
    logic    mem2reg;
    logic    reg_write;
  } ctrl_t;

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational opcode decode: control bundle, illegal flag, which source
// registers the instruction reads, and whether its immediate is zero-extended.
module id_ctrl_decode
  import id_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o,
  output logic       rs_used_o,
  output logic       rt_used_o,
  output logic       zext_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    rs_used_o = 1'b1;
    rt_used_o = 1'b0;
    zext_o    = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.alu_op    = ALUOP_RTYPE;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        rt_used_o        = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.mem2reg   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        rt_used_o        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.alu_op = ALUOP_BRANCH;
        ctrl_o.branch = 1'b1;
        rt_used_o     = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_ANDI: begin
        ctrl_o.alu_op    = ALUOP_AND;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        zext_o           = 1'b1;
      end
      OP_ORI: begin
        ctrl_o.alu_op    = ALUOP_OR;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        zext_o           = 1'b1;
      end
      OP_SLTI: begin
        ctrl_o.alu_op    = ALUOP_SLT;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LUI: begin
        // lui builds its result from the immediate alone
        ctrl_o.alu_op    = ALUOP_LUI;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        rs_used_o        = 1'b0;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined MIPS decode stage: operand bypass from WB, load-use bubble
// insertion, flush/stall priority and a saturating bubble counter.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ID_valid,
  input  logic [31:0]       i_ID_data_instruction,
  input  logic [DATA_W-1:0] i_EX_data_PCNext,
  input  logic [DATA_W-1:0] i_ID_reg_RegData1,
  input  logic [DATA_W-1:0] i_ID_reg_RegData2,
  input  logic              i_WB_ctrl_RegWrite,
  input  logic [REG_AW-1:0] i_WB_data_RegAddr,
  input  logic [DATA_W-1:0] i_WB_data_RegData,
  input  logic              i_EX_stall,
  input  logic              i_flush,
  output logic [REG_AW-1:0] o_ID_reg_RegAddr1,
  output logic [REG_AW-1:0] o_ID_reg_RegAddr2,
  output logic              o_IF_stall,
  output logic              o_EX_valid,
  output logic [DATA_W-1:0] o_EX_data_RSData,
  output logic [DATA_W-1:0] o_MEM_data_RTData,
  output logic [DATA_W-1:0] o_EX_data_AddrOffset,
  output logic [DATA_W-1:0] o_EX_data_PCNext,
  output logic [REG_AW-1:0] o_EX_data_RTAddr,
  output logic [REG_AW-1:0] o_EX_data_RDAddr,
  output logic [REG_AW-1:0] o_EX_data_Shamt,
  output logic [5:0]        o_EX_data_Funct,
  output logic [3:0]        o_EX_ctrl_ALUOp,
  output logic              o_EX_ctrl_ALUSrc,
  output logic              o_EX_ctrl_RegDst,
  output logic              o_MEM_ctrl_MemWrite,
  output logic              o_MEM_ctrl_MemRead,
  output logic              o_MEM_ctrl_Branch,
  output logic              o_WB_ctrl_Mem2Reg,
  output logic              o_WB_ctrl_RegWrite,
  output logic              o_ID_illegal,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic              illegal;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] shamt;
    logic [5:0]        funct;
  } idex_t;

  idex_t idex_q, idex_d, dec_pkt;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t dec_ctrl;
  logic  dec_illegal, rs_used, rt_used, zext;

  logic [REG_AW-1:0] rs, rt;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
  logic              wb_hit_rs, wb_hit_rt, hz;

  id_ctrl_decode u_dec (
    .opcode_i  (i_ID_data_instruction[31:26]),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .rs_used_o (rs_used),
    .rt_used_o (rt_used),
    .zext_o    (zext)
  );

  assign rs    = REG_AW'(i_ID_data_instruction[25:21]);
  assign rt    = REG_AW'(i_ID_data_instruction[20:16]);
  assign imm16 = i_ID_data_instruction[15:0];

  assign o_ID_reg_RegAddr1 = rs;
  assign o_ID_reg_RegAddr2 = rt;

  assign wb_hit_rs = (WB_BYPASS != 0) && i_WB_ctrl_RegWrite &&
                     (i_WB_data_RegAddr != '0) && (i_WB_data_RegAddr == rs);
  assign wb_hit_rt = (WB_BYPASS != 0) && i_WB_ctrl_RegWrite &&
                     (i_WB_data_RegAddr != '0) && (i_WB_data_RegAddr == rt);

  // $0 is hard-wired, whatever the register file array happens to return
  assign rs_val = (rs == '0) ? '0 : (wb_hit_rs ? i_WB_data_RegData : i_ID_reg_RegData1);
  assign rt_val = (rt == '0) ? '0 : (wb_hit_rt ? i_WB_data_RegData : i_ID_reg_RegData2);

  assign imm_ext = zext ? {{(DATA_W-16){1'b0}}, imm16}
                        : {{(DATA_W-16){imm16[15]}}, imm16};

  assign hz = i_ID_valid && idex_q.valid && idex_q.ctrl.mem_read &&
              idex_q.ctrl.reg_write && (idex_q.rt_addr != '0) &&
              ((rs_used && (idex_q.rt_addr == rs)) ||
               (rt_used && (idex_q.rt_addr == rt)));

  assign o_IF_stall = !i_flush && (i_EX_stall || hz);

  always_comb begin
    dec_pkt         = '0;
    dec_pkt.valid   = 1'b1;
    dec_pkt.ctrl    = dec_ctrl;
    dec_pkt.illegal = dec_illegal;
    dec_pkt.rs_data = rs_val;
    dec_pkt.rt_data = rt_val;
    dec_pkt.imm     = imm_ext;
    dec_pkt.pc      = i_EX_data_PCNext;
    dec_pkt.rt_addr = rt;
    dec_pkt.rd_addr = REG_AW'(i_ID_data_instruction[15:11]);
    dec_pkt.shamt   = REG_AW'(i_ID_data_instruction[10:6]);
    dec_pkt.funct   = i_ID_data_instruction[5:0];
    if (!i_ID_valid) dec_pkt = '0;
  end

  always_comb begin
    idex_d = dec_pkt;
    cnt_d  = cnt_q;
    if (i_flush) begin
      idex_d = '0;
    end else if (i_EX_stall) begin
      idex_d = idex_q;
    end else if (hz) begin
      idex_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_EX_valid           = idex_q.valid;
  assign o_EX_data_RSData     = idex_q.rs_data;
  assign o_MEM_data_RTData    = idex_q.rt_data;
  assign o_EX_data_AddrOffset = idex_q.imm;
  assign o_EX_data_PCNext     = idex_q.pc;
  assign o_EX_data_RTAddr     = idex_q.rt_addr;
  assign o_EX_data_RDAddr     = idex_q.rd_addr;
  assign o_EX_data_Shamt      = idex_q.shamt;
  assign o_EX_data_Funct      = idex_q.funct;
  assign o_EX_ctrl_ALUOp      = idex_q.ctrl.alu_op;
  assign o_EX_ctrl_ALUSrc     = idex_q.ctrl.alu_src;
  assign o_EX_ctrl_RegDst     = idex_q.ctrl.reg_dst;
  assign o_MEM_ctrl_MemWrite  = idex_q.ctrl.mem_write;
  assign o_MEM_ctrl_MemRead   = idex_q.ctrl.mem_read;
  assign o_MEM_ctrl_Branch    = idex_q.ctrl.branch;
  assign o_WB_ctrl_Mem2Reg    = idex_q.ctrl.mem2reg;
  assign o_WB_ctrl_RegWrite   = idex_q.ctrl.reg_write;
  assign o_ID_illegal         = idex_q.illegal;
  assign o_stall_cnt          = cnt_q;

endmodule
